cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle fetch/decode/execute controller for the accumulator CPU. It owns the program counter and instruction register and runs a shared instruction/data memory through a req/ack handshake. It drives the accumulator datapath with one write strobe and a 4-bit ALU code per instruction. It halts on `stp` and resumes on `run`.

## Interface
- `ADDR_W`, default 4: memory address width. It is also the width of the instruction operand field.
- `INS_W`, default `4+ADDR_W`: instruction width. The format is `{opcode[3:0], operand[ADDR_W-1:0]}`.
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `run`  in  1  level. Sampled only in HALT, where it starts or resumes execution.
- `mem_rdata`  in  INS_W  memory read data. Valid when `mem_ack`=1.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write request. Data comes from the accumulator, outside this block.
- `mem_addr`  out  ADDR_W  request address.
- `acc_wr`  out  1  accumulator write strobe.
- `alu_code`  out  4  ALU operation select.
- `halted`  out  1  sequencer is in HALT.
- `pc`  out  ADDR_W  current program counter.
- `ir_opcode`  out  4  latched opcode.

## Operation
**Decode.** The opcode is a prefix code on `ir[INS_W-1:INS_W-4]`:

| Opcode | Instruction | ALU code | Class |
|---|---|---|---|
| 000x | add | 0100 | mem-read |
| 001x | sta | 0101 | mem-write |
| 010x | lda | 0110 | mem-read |
| 011x | cla | 0000 | acc-only |
| 100x | com | 0001 | acc-only |
| 101x | jmp | 1111 | jump |
| 1100 | ban | 0111 | mem-read |
| 1101 | shr | 0010 | acc-only |
| 1110 | csl | 0011 | acc-only |
| 1111 | stp | 1111 | halt |

**States.** The sequencer has four states: HALT, FETCH, DECODE, EXEC.
- **HALT**
  - All strobes are 0 and `halted`=1.
  - `run`=1 moves to FETCH. Otherwise it stays in HALT.
- **FETCH**
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - Holds until `mem_ack`.
  - On ack: `ir`<=`mem_rdata`, `pc`<=`pc+1` modulo 2^ADDR_W, then go to DECODE.
- **DECODE**
  - Lasts one cycle with no strobes.
  - Registers `alu_code` and the instruction class.
  - Goes to EXEC, except `stp`, which goes to HALT.
- **EXEC**, mem-read:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=operand, held until ack.
  - `acc_wr`=`mem_ack` in the same cycle, so the datapath captures `mem_rdata` together with `alu_code`.
  - Then go to FETCH.
- **EXEC**, mem-write:
  - `mem_req`=1, `mem_we`=1, `mem_addr`=operand, held until ack.
  - `acc_wr`=0.
  - Then go to FETCH.
- **EXEC**, acc-only: `acc_wr`=1 for exactly one cycle, then go to FETCH.
- **EXEC**, jump: `pc`<=operand for one cycle with no strobes, then go to FETCH.

**Output rules.**
- `alu_code` is valid from the cycle after DECODE through the end of EXEC. It is 0000 in every other state.
- `mem_addr` equals `pc` whenever `mem_req`=0.
- Request address and `mem_we` are stable while `mem_req`=1 and `mem_ack`=0.
- `mem_ack` while `mem_req`=0 is ignored.
- `ir` changes only on a FETCH ack.

## Timing
**Reset.** `rst` is synchronous, takes priority, and is honoured in any state. The next cycle the block is in HALT with:
- `pc`=0, `ir`=0, `ir_opcode`=0
- `mem_req`=0, `mem_we`=0, `acc_wr`=0
- `alu_code`=0000, `halted`=1

**Reset mid-operation.** An outstanding request is dropped without waiting for ack. The memory tolerates an aborted request. A late ack arriving after reset is ignored because the block is in HALT.

**Latency with zero-wait memory** (ack in the same cycle as req): every instruction takes 3 cycles (FETCH, DECODE, EXEC). Each wait cycle adds 1 cycle to FETCH and/or EXEC.

**Halt.**
- `stp` reaches HALT 2 cycles after its fetch ack. At that point `pc` already points past the `stp`.
- `run` held high in HALT enters FETCH on the next cycle.
- `run` is ignored outside HALT.

**Back-to-back.** A new FETCH request follows immediately after EXEC completes. There is no idle cycle.

**PC wrap.** PC increments wrap modulo 2^ADDR_W, so a fetch at 0xF is followed by a fetch at 0x0. `jmp` overrides the increment.

## Test plan
- **Reset and lda.** Reset, `run`=1, memory[0]=0x45 (lda 5), zero-wait memory.
  - Cycle 1: fetch request at address 0.
  - Cycle 3: request at address 5 with `acc_wr`=1 and `alu_code`=0110.
  - Cycle 4: fetch at address 1.
- **sta with wait states.** memory[0]=0x27 (sta 7), ack delayed 2 cycles.
  - `mem_req`/`mem_we`=1 with `mem_addr`=7 held for 3 cycles.
  - `acc_wr` never asserts.
  - Next fetch is at address 1.
- **jmp.** memory[0]=0xAA (jmp 0xA).
  - No `acc_wr` and no EXEC request.
  - Next fetch is at address 0xA and `pc`=0xA.
- **PC wrap.** `pc`=0xF, memory[0xF]=0x60 (cla).
  - One-cycle `acc_wr` with `alu_code`=0000.
  - Next fetch is at address 0x0.
- **Halt and resume.** memory[3]=0xF0 (stp), with `run` low after start.
  - `halted`=1 two cycles after the fetch ack, and no further `mem_req`.
  - Raising `run` produces a fetch at address 4.
- **Reset mid-fetch.** Assert `rst` during a FETCH that is awaiting ack.
  - Next cycle: `mem_req`=0, `halted`=1, `pc`=0.
  - A late `mem_ack` causes no state change.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the accumulator CPU: owns PC and IR and
// runs the shared instruction/data memory over a req/ack handshake.
module cpu_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INS_W  = 4 + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [INS_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              acc_wr,
  output logic [3:0]        alu_code,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        ir_opcode
);

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_DECODE, S_EXEC} state_e;
  typedef enum logic [1:0] {C_RD, C_WR, C_ACC, C_JMP} cls_e;

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INS_W-1:0]    ir_q, ir_d;
  logic [3:0]          alu_q, alu_d;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [3:0]          dec_alu;
  cls_e                dec_cls;
  logic                dec_stp;

  assign opcode  = ir_q[INS_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];

  always_comb begin
    dec_alu = 4'b0000;
    dec_cls = C_ACC;
    dec_stp = 1'b0;
    unique casez (opcode)
      4'b000?: begin dec_alu = 4'b0100; dec_cls = C_RD;  end
      4'b001?: begin dec_alu = 4'b0101; dec_cls = C_WR;  end
      4'b010?: begin dec_alu = 4'b0110; dec_cls = C_RD;  end
      4'b011?: begin dec_alu = 4'b0000; dec_cls = C_ACC; end
      4'b100?: begin dec_alu = 4'b0001; dec_cls = C_ACC; end
      4'b101?: begin dec_alu = 4'b1111; dec_cls = C_JMP; end
      4'b1100: begin dec_alu = 4'b0111; dec_cls = C_RD;  end
      4'b1101: begin dec_alu = 4'b0010; dec_cls = C_ACC; end
      4'b1110: begin dec_alu = 4'b0011; dec_cls = C_ACC; end
      4'b1111: begin dec_alu = 4'b1111; dec_stp = 1'b1;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_d    = alu_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    acc_wr   = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_stp) begin
          state_d = S_HALT;
        end else begin
          alu_d   = dec_alu;
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (cls_q)
          C_RD: begin
            mem_req  = 1'b1;
            mem_addr = operand;
            acc_wr   = mem_ack;
            if (mem_ack) state_d = S_FETCH;
          end
          C_WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = operand;
            if (mem_ack) state_d = S_FETCH;
          end
          C_ACC: begin
            acc_wr  = 1'b1;
            state_d = S_FETCH;
          end
          C_JMP: begin
            pc_d    = operand;
            state_d = S_FETCH;
          end
          default: ;
        endcase
        // ALU code is only meaningful while EXEC lasts
        if (state_d != S_EXEC) alu_d = 4'b0000;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HALT;
      cls_q   <= C_ACC;
      pc_q    <= '0;
      ir_q    <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
    end
  end

  assign alu_code  = alu_q;
  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;
  assign ir_opcode = opcode;

endmodule
